// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller.
//   Detects load-use hazards, freezes the pipeline while data memory is busy,
//   and flushes wrong-path instructions when a taken branch resolves in MEM.
//   Control outputs are combinational from state and inputs, so they act in
//   the same cycle. Stall/flush event counters are registered.
// Ports:
//   clk, reset_n          - rising-edge clock, synchronous active-low reset
//   IDEX_MemRead/IDEX_rd  - load flag and destination of the instruction in EX
//   IFID_rs1/rs2, uses_*  - source fields and use flags of the instruction in ID
//   branch_taken          - taken branch/jump resolved in MEM
//   mem_busy              - data memory not ready, whole pipeline holds
//   PCWrite, IFID_Write   - PC and IF/ID load enables (0 = hold)
//   Flushout, IDEX_Bubble, EXMEM_Flush - zero/NOP controls for the next edge
//   stall_cnt, flush_cnt  - load-use bubble cycles / branch flush events
module hazard_ctrl #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             IDEX_MemRead,
    input  logic [4:0]       IDEX_rd,
    input  logic [4:0]       IFID_rs1,
    input  logic [4:0]       IFID_rs2,
    input  logic             uses_rs1,
    input  logic             uses_rs2,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             PCWrite,
    output logic             IFID_Write,
    output logic             Flushout,
    output logic             IDEX_Bubble,
    output logic             EXMEM_Flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {RUN, STALL} state_t;

    // Bubbles still owed after the first one, loaded when a hazard is seen.
    localparam logic [3:0]       REM_INIT = 4'(LOAD_STALL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [3:0]       r_rem;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_hz;
    logic w_stall;

    // x0 is never a real dependency, so a load to x0 never stalls.
    assign w_hz = IDEX_MemRead && (IDEX_rd != 5'd0) &&
                  ((uses_rs1 && (IDEX_rd == IFID_rs1)) ||
                   (uses_rs2 && (IDEX_rd == IFID_rs2)));

    assign w_stall = (r_state == STALL) || w_hz;

    // Priority: reset, freeze, flush, stall, run.
    always_comb begin
        PCWrite     = 1'b1;
        IFID_Write  = 1'b1;
        Flushout    = 1'b0;
        IDEX_Bubble = 1'b0;
        EXMEM_Flush = 1'b0;
        if (!reset_n) begin
            // keep RUN-idle values while reset is held
        end else if (mem_busy) begin
            PCWrite    = 1'b0;
            IFID_Write = 1'b0;
        end else if (branch_taken) begin
            Flushout    = 1'b1;
            IDEX_Bubble = 1'b1;
            EXMEM_Flush = 1'b1;
        end else if (w_stall) begin
            PCWrite     = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Bubble = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= RUN;
            r_rem       <= 4'd0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (!mem_busy) begin
            // While frozen, EX/MEM holds the branch, so it is acted on later.
            if (branch_taken) begin
                r_state     <= RUN;
                r_rem       <= 4'd0;
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            end else if (r_state == STALL) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
                r_rem       <= r_rem - 4'd1;
                if (r_rem == 4'd1) begin
                    r_state <= RUN;
                end
            end else if (w_hz) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
                if (LOAD_STALL_CYCLES > 1) begin
                    r_state <= STALL;
                    r_rem   <= REM_INIT;
                end
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller that drives the hold and flush controls of the IF/ID stage register: `IFID_Write` and `Flushout`.
- Also drives `PCWrite`, the ID/EX bubble and the EX/MEM flush.
- Detects load-use hazards, freezes the pipeline while data memory is busy, and flushes wrong-path instructions when a taken branch resolves in MEM.
- Keeps 32-bit stall and flush event counters for performance debug.

Parameters:
- LOAD_STALL_CYCLES, 1, number of bubbles inserted per load-use hazard (1..15).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous, active-low reset.
- IDEX_MemRead  input  1  instruction in EX is a load.
- IDEX_rd  input  5  destination register of the instruction in EX.
- IFID_rs1  input  5  rs1 field of the instruction in ID.
- IFID_rs2  input  5  rs2 field of the instruction in ID.
- uses_rs1  input  1  instruction in ID reads rs1.
- uses_rs2  input  1  instruction in ID reads rs2.
- branch_taken  input  1  taken branch/jump resolved in MEM (from EX/MEM).
- mem_busy  input  1  data memory not ready; the whole pipeline must hold.
- PCWrite  output  1  PC update enable.
- IFID_Write  output  1  IF/ID load enable (0 = hold).
- Flushout  output  1  zero IF/ID on the next edge.
- IDEX_Bubble  output  1  load NOP control into ID/EX on the next edge.
- EXMEM_Flush  output  1  zero EX/MEM on the next edge.
- stall_cnt  output  CNT_W  count of load-use bubble cycles.
- flush_cnt  output  CNT_W  count of branch flush events.

Behaviour:
- Reset: when reset_n is 0 at a rising edge:
  - state becomes RUN, rem becomes 0, stall_cnt and flush_cnt become 0.
  - While reset_n is low, all outputs are forced to the RUN-idle values: PCWrite=1, IFID_Write=1, Flushout=0, IDEX_Bubble=0, EXMEM_Flush=0.
  - Reset mid-stall or mid-freeze aborts the event immediately; no counter increment occurs on the reset edge.
- State: 2-state FSM {RUN, STALL} plus a 4-bit remaining-bubble counter `rem`. Control outputs are combinational from state and inputs (zero latency). Counters are registered.
- hz (load-use hazard) = IDEX_MemRead & (IDEX_rd != 0) & ((uses_rs1 & IDEX_rd == IFID_rs1) | (uses_rs2 & IDEX_rd == IFID_rs2)).
- Priority, highest first: mem_busy, then branch_taken, then stall (hz in RUN, or state STALL), then run.
- Freeze (mem_busy=1):
  - PCWrite=0, IFID_Write=0; Flushout, IDEX_Bubble and EXMEM_Flush all 0.
  - state, rem and the counters hold.
  - branch_taken is ignored and is acted on the first cycle mem_busy=0; EX/MEM is frozen, so branch_taken stays asserted.
- Flush (branch_taken=1, mem_busy=0):
  - Flushout=1, IDEX_Bubble=1, EXMEM_Flush=1, PCWrite=1, IFID_Write=1.
  - Next state is RUN and rem becomes 0; an in-progress stall is cancelled.
  - flush_cnt increments by 1.
- Stall, in RUN with hz=1:
  - PCWrite=0, IFID_Write=0, IDEX_Bubble=1, Flushout=0, EXMEM_Flush=0.
  - stall_cnt increments by 1.
  - If LOAD_STALL_CYCLES>1: next state is STALL and rem becomes LOAD_STALL_CYCLES-1. Otherwise the state stays RUN.
- Stall, in STALL:
  - Same outputs as the RUN stall; stall_cnt increments by 1.
  - rem decrements; when rem==1 at the edge, the next state is RUN.
- Run: PCWrite=1, IFID_Write=1, all flush/bubble outputs 0.
- Counters wrap modulo 2^CNT_W without saturation.
- Outputs are never X after reset, for any input combination.

Test Plan:
- Reset: reset_n=0 for 2 cycles with mem_busy=1 and branch_taken=1 -> PCWrite=1, IFID_Write=1, Flushout=0, IDEX_Bubble=0, EXMEM_Flush=0; after reset release, stall_cnt=0 and flush_cnt=0.
- Load-use, default param: IDEX_MemRead=1, IDEX_rd=5, IFID_rs2=5, uses_rs2=1 for one cycle -> exactly one cycle with PCWrite=0, IFID_Write=0, IDEX_Bubble=1; stall_cnt=1. Repeat with IDEX_rd=0 -> no stall.
- Multi-bubble: LOAD_STALL_CYCLES=3, hazard present for 1 cycle -> 3 consecutive stall cycles, then PCWrite=1; stall_cnt=3.
- Branch beats stall: LOAD_STALL_CYCLES=3, branch_taken=1 in the 2nd stall cycle -> in that cycle Flushout=1, EXMEM_Flush=1, PCWrite=1; next cycle RUN; flush_cnt=1, stall_cnt=1.
- Freeze defers flush: mem_busy=1 for 4 cycles with branch_taken=1 throughout -> PCWrite=0, IFID_Write=0, Flushout=0 for all 4 cycles; the cycle after mem_busy falls -> Flushout=1 and flush_cnt=1.
- Reset mid-stall: LOAD_STALL_CYCLES=4, reset_n=0 in the 2nd stall cycle -> next cycle is RUN with rem=0 and stall_cnt=0.
